pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Multi-lane pipeline stage register with per-lane valid bits,
//             valid/ready backpressure via a two-entry skid buffer, whole
//             stage flush and per-lane kill of the main entry.
//  Ports    : clk, areset_n         - clock, async active-low reset
//             in_valid/in_data      - incoming bundle (lane i at [i*WIDTH +: WIDTH])
//             in_ready              - registered accept indication
//             out_valid/out_data    - held bundle (main entry), kill-masked valid
//             out_ready             - downstream accept
//             flush                 - synchronous squash of all held bundles
//             kill_mask             - per-lane squash of the main entry
//             occupancy             - number of bundles held (0..2)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 WIDTH       = 32,
    parameter int                 LANES       = 2,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic [LANES-1:0]         in_valid,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     in_ready,
    output logic [LANES-1:0]         out_valid,
    output logic [LANES*WIDTH-1:0]   out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic [LANES-1:0]         kill_mask,
    output logic [1:0]               occupancy
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [LANES*WIDTH-1:0] c_RESET_BUNDLE = {LANES{RESET_VALUE}};

    state_t                    r_state_q,      w_state_d;
    logic [LANES-1:0]          r_main_valid_q, w_main_valid_d;
    logic [LANES*WIDTH-1:0]    r_main_data_q,  w_main_data_d;
    logic [LANES-1:0]          r_skid_valid_q, w_skid_valid_d;
    logic [LANES*WIDTH-1:0]    r_skid_data_q,  w_skid_data_d;
    logic                      r_in_ready_q,   w_in_ready_d;

    logic [LANES-1:0]          w_out_valid;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_main_free;

    // Kill only masks the main entry; it is the sole combinational path to outputs.
    assign w_out_valid = (r_state_q == S_EMPTY) ? '0 : (r_main_valid_q & ~kill_mask);
    assign w_in_fire   = r_in_ready_q & (|in_valid);
    assign w_out_fire  = out_ready & (|w_out_valid);
    // A fully killed main entry is dropped without waiting for the consumer.
    assign w_main_free = w_out_fire | ((r_state_q != S_EMPTY) & ~(|w_out_valid));

    always_comb begin
        w_state_d      = r_state_q;
        w_main_valid_d = r_main_valid_q & ~kill_mask;
        w_main_data_d  = r_main_data_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_data_d  = r_skid_data_q;

        case (r_state_q)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_d      = S_ONE;
                    w_main_valid_d = in_valid;
                    w_main_data_d  = in_data;
                end
            end
            S_ONE: begin
                if (w_main_free && w_in_fire) begin
                    w_main_valid_d = in_valid;
                    w_main_data_d  = in_data;
                end else if (w_main_free) begin
                    w_state_d      = S_EMPTY;
                    w_main_valid_d = '0;
                end else if (w_in_fire) begin
                    w_state_d      = S_FULL;
                    w_skid_valid_d = in_valid;
                    w_skid_data_d  = in_data;
                end
            end
            S_FULL: begin
                if (w_main_free) begin
                    w_state_d      = S_ONE;
                    w_main_valid_d = r_skid_valid_q;
                    w_main_data_d  = r_skid_data_q;
                    w_skid_valid_d = '0;
                end
            end
            default: begin
                w_state_d      = S_EMPTY;
                w_main_valid_d = '0;
                w_skid_valid_d = '0;
            end
        endcase

        // Flush drops everything including a bundle accepted this cycle;
        // payload registers keep their previous contents.
        if (flush) begin
            w_state_d      = S_EMPTY;
            w_main_valid_d = '0;
            w_skid_valid_d = '0;
            w_main_data_d  = r_main_data_q;
            w_skid_data_d  = r_skid_data_q;
        end

        // Ready is registered from the next state so out_ready never reaches in_ready.
        w_in_ready_d = (w_state_d != S_FULL);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state_q      <= S_EMPTY;
            r_main_valid_q <= '0;
            r_main_data_q  <= c_RESET_BUNDLE;
            r_skid_valid_q <= '0;
            r_skid_data_q  <= c_RESET_BUNDLE;
            r_in_ready_q   <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_main_valid_q <= w_main_valid_d;
            r_main_data_q  <= w_main_data_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_data_q  <= w_skid_data_d;
            r_in_ready_q   <= w_in_ready_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data_q;
    assign occupancy = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed table-driven checks of pipe_stage_reg (2 lanes x 32 bits)
//             plus hand-written asynchronous reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          c_WIDTH = 32;
    localparam int          c_LANES = 2;
    localparam logic [31:0] c_RV    = 32'hDEAD_BEEF;
    localparam logic [63:0] c_RV2   = {c_RV, c_RV};

    localparam logic [63:0] c_DA = 64'h0000_00A1_0000_00A0;
    localparam logic [63:0] c_DB = 64'h0000_00B1_0000_00B0;
    localparam logic [63:0] c_DC = 64'h0000_00C1_0000_00C0;
    localparam logic [63:0] c_DD = 64'h0000_00D1_0000_00D0;
    localparam logic [63:0] c_DP = 64'h1234_5678_0000_00F0;
    localparam logic [63:0] c_DK = 64'h0000_0E11_0000_0E10;
    localparam logic [63:0] c_DL = 64'h0000_0E21_0000_0E20;
    localparam logic [63:0] c_DM = 64'h0000_0E31_0000_0E30;
    localparam logic [63:0] c_DN = 64'h0000_0E41_0000_0E40;
    localparam logic [63:0] c_DQ = 64'h0000_0E51_0000_0E50;
    localparam logic [63:0] c_DR = 64'h0000_0E61_0000_0E60;

    logic        clk;
    logic        areset_n;
    logic [1:0]  in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        flush;
    logic [1:0]  kill_mask;
    logic [1:0]  occupancy;

    int checks;
    int failures;

    pipe_stage_reg #(
        .WIDTH       (c_WIDTH),
        .LANES       (c_LANES),
        .RESET_VALUE (c_RV)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .kill_mask (kill_mask),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  iv;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic [1:0]  kl;
        logic [1:0]  eov;
        logic [63:0] eod;
        logic        eir;
        logic [1:0]  eocc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] iv, input logic [63:0] d, input logic ordy,
                       input logic fl, input logic [1:0] kl, input logic [1:0] eov,
                       input logic [63:0] eod, input logic eir, input logic [1:0] eocc);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.kl = kl;
        v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input logic [1:0] eov, input logic [63:0] eod,
                             input logic eir, input logic [1:0] eocc);
        check("out_valid", row, {62'd0, out_valid}, {62'd0, eov});
        check("out_data",  row, out_data, eod);
        check("in_ready",  row, {63'd0, in_ready}, {63'd0, eir});
        check("occupancy", row, {62'd0, occupancy}, {62'd0, eocc});
    endtask

    task automatic drive(input logic [1:0] iv, input logic [63:0] d, input logic ordy,
                         input logic fl, input logic [1:0] kl);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl; kill_mask = kl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        areset_n = 1'b0;
        drive(2'b00, 64'd0, 1'b0, 1'b0, 2'b00);

        //   iv     data  ordy fl kill | eov    eod    eir eocc
        // Reset then stream at full rate
        add(2'b11, c_DA, 1, 0, 2'b00,  2'b00, c_RV2, 1, 2'd0);
        add(2'b11, c_DB, 1, 0, 2'b00,  2'b11, c_DA,  1, 2'd1);
        add(2'b11, c_DC, 1, 0, 2'b00,  2'b11, c_DB,  1, 2'd1);
        add(2'b00, c_DD, 1, 0, 2'b00,  2'b11, c_DC,  1, 2'd1);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DC,  1, 2'd0);
        // Backpressure: A main, B skid, C refused then taken
        add(2'b11, c_DA, 0, 0, 2'b00,  2'b00, c_DC,  1, 2'd0);
        add(2'b11, c_DB, 0, 0, 2'b00,  2'b11, c_DA,  1, 2'd1);
        add(2'b11, c_DC, 0, 0, 2'b00,  2'b11, c_DA,  0, 2'd2);
        add(2'b11, c_DC, 1, 0, 2'b00,  2'b11, c_DA,  0, 2'd2);
        add(2'b11, c_DC, 1, 0, 2'b00,  2'b11, c_DB,  1, 2'd1);
        add(2'b00, c_DD, 1, 0, 2'b00,  2'b11, c_DC,  1, 2'd1);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DC,  1, 2'd0);
        // Bubbles are never stored; partial valid keeps lane 1 payload
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DC,  1, 2'd0);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DC,  1, 2'd0);
        add(2'b01, c_DP, 0, 0, 2'b00,  2'b00, c_DC,  1, 2'd0);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b01, c_DP,  1, 2'd1);
        add(2'b00, c_DD, 1, 0, 2'b00,  2'b01, c_DP,  1, 2'd1);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DP,  1, 2'd0);
        // Kill: lane 1 killed sticks; full kill with skid releases main
        add(2'b11, c_DK, 0, 0, 2'b00,  2'b00, c_DP,  1, 2'd0);
        add(2'b00, c_DD, 0, 0, 2'b10,  2'b01, c_DK,  1, 2'd1);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b01, c_DK,  1, 2'd1);
        add(2'b11, c_DL, 0, 0, 2'b00,  2'b01, c_DK,  1, 2'd1);
        add(2'b00, c_DD, 0, 0, 2'b11,  2'b00, c_DK,  0, 2'd2);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b11, c_DL,  1, 2'd1);
        // Flush while FULL (with kill and input present), then flush in ONE with in_fire
        add(2'b11, c_DM, 0, 0, 2'b00,  2'b11, c_DL,  1, 2'd1);
        add(2'b11, c_DN, 1, 1, 2'b01,  2'b10, c_DL,  0, 2'd2);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DL,  1, 2'd0);
        add(2'b11, c_DQ, 0, 0, 2'b00,  2'b00, c_DL,  1, 2'd0);
        add(2'b11, c_DR, 1, 1, 2'b00,  2'b11, c_DQ,  1, 2'd1);
        add(2'b00, c_DD, 0, 0, 2'b00,  2'b00, c_DQ,  1, 2'd0);

        // Reset state, checked while reset is held
        #12;
        check_all(-1, 2'b00, c_RV2, 1'b1, 2'd0);
        areset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].kl);
            #2;
            check_all(i, vecs[i].eov, vecs[i].eod, vecs[i].eir, vecs[i].eocc);
            @(posedge clk); #1;
        end

        // Asynchronous reset while FULL, between clock edges
        drive(2'b11, c_DA, 1'b0, 1'b0, 2'b00);
        @(posedge clk); #1;
        drive(2'b11, c_DB, 1'b0, 1'b0, 2'b00);
        @(posedge clk); #1;
        check_all(100, 2'b11, c_DA, 1'b0, 2'd2);
        #2;
        areset_n = 1'b0;
        #1;
        check_all(101, 2'b00, c_RV2, 1'b1, 2'd0);
        drive(2'b11, c_DC, 1'b1, 1'b0, 2'b00);
        @(posedge clk); #1;
        check_all(102, 2'b00, c_RV2, 1'b1, 2'd0);
        #2;
        areset_n = 1'b1;
        @(posedge clk); #1;
        check_all(103, 2'b11, c_DC, 1'b1, 2'd1);
        drive(2'b00, c_DD, 1'b1, 1'b0, 2'b00);
        @(posedge clk); #1;
        check_all(104, 2'b00, c_DC, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
